// File: rtl/pe_drain_if.sv
// Valid/ready output port of pe_drain: show-ahead head word plus handshake.
interface pe_drain_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             i_ready;

  modport master (output o_data, output o_valid, input i_ready);
  modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/pe_drain.sv
// pe_drain: samples an edge PE word for WORDS cycles into a FIFO and drains it
// over valid/ready. Optional address check enabled by PE_DRAIN_ADDR_CHECK_EN.
module pe_drain #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 3,
  parameter int WORDS      = 8,
  parameter int DEPTH      = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE,
  pe_drain_if.master                       drain,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_overflow,
  output logic                             o_addr_err
);
  localparam int W     = ADDR_WIDTH + DATA_WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] FLUSH   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [PTR_W:0]   FULL_OCC = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

  logic [1:0]       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]   occ_r;
  logic [W-1:0]     mem_r [DEPTH];
  logic             busy_r, done_r, overflow_r;
  logic             start_s, capture_s, valid_s, full_s, pop_s, push_s, drop_s;

  // Handshake and FIFO status decode; a full FIFO still accepts when it pops
  always_comb begin
    start_s   = (state_r == IDLE) && i_start;
    capture_s = (state_r == CAPTURE);
    valid_s   = (occ_r != {(PTR_W + 1){1'b0}});
    full_s    = (occ_r == FULL_OCC);
    pop_s     = valid_s && drain.i_ready;
    push_s    = capture_s && (!full_s || pop_s);
    drop_s    = capture_s && full_s && !pop_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_start) state_nxt_s = CAPTURE;
        else         state_nxt_s = IDLE;
      end
      CAPTURE: begin
        if (cnt_r == LAST_IDX) state_nxt_s = FLUSH;
        else                   state_nxt_s = CAPTURE;
      end
      FLUSH: begin
        if (!valid_s) state_nxt_s = DONE;
        else          state_nxt_s = FLUSH;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register with busy/done registered from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Sample counter and sticky overflow; dropped samples still advance the count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r      <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else if (start_s) begin
      cnt_r      <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else if (capture_s) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
      if (drop_s) overflow_r <= 1'b1;
    end
  end

  // FIFO storage, wrapping pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {(PTR_W + 1){1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= i_PE;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + (PTR_W + 1)'(1'b1);
        2'b01:   occ_r <= occ_r - (PTR_W + 1)'(1'b1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign drain.o_valid = valid_s;
  assign drain.o_data  = valid_s ? mem_r[rd_ptr_r] : {W{1'b0}};
  assign o_busy        = busy_r;
  assign o_done        = done_r;
  assign o_overflow    = overflow_r;

`ifdef PE_DRAIN_ADDR_CHECK_EN
  logic addr_mis_s;
  logic addr_err_r;

  if (ADDR_WIDTH <= CNT_W) begin : g_cmp_narrow
    assign addr_mis_s = (i_PE[W-1:DATA_WIDTH] != cnt_r[ADDR_WIDTH-1:0]);
  end else begin : g_cmp_wide
    assign addr_mis_s = (i_PE[W-1:DATA_WIDTH] != {{(ADDR_WIDTH - CNT_W){1'b0}}, cnt_r});
  end

  // Sticky address mismatch, checked on every captured sample including drops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          addr_err_r <= 1'b0;
    else if (start_s)                  addr_err_r <= 1'b0;
    else if (capture_s && addr_mis_s)  addr_err_r <= 1'b1;
    else                               addr_err_r <= addr_err_r;
  end

  assign o_addr_err = addr_err_r;
`else
  assign o_addr_err = 1'b0;
`endif
endmodule
